// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: single-port memory sequencer, data access beats fetch, flushed fetches return NOP
module imem_dmem_arbiter #(
    parameter logic [31:0] NOP_INSTR = 32'hE000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_if_req,
    input  logic [31:0]      i_if_addr,
    input  logic             i_flush,
    output logic [31:0]      o_if_instr,
    output logic             o_if_ready,
    input  logic             i_dm_rd,
    input  logic             i_dm_wr,
    input  logic [31:0]      i_dm_addr,
    input  logic [31:0]      i_dm_wdata,
    output logic [31:0]      o_dm_rdata,
    output logic             o_dm_done,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [31:0]      o_mem_addr,
    output logic [31:0]      o_mem_wdata,
    input  logic [31:0]      i_mem_rdata,
    input  logic             i_mem_ack,
    output logic [CNT_W-1:0] o_stall_cycles
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DATA  = 3'd1;
    localparam logic [2:0] DDONE = 3'd2;
    localparam logic [2:0] FETCH = 3'd3;
    localparam logic [2:0] FDONE = 3'd4;
    logic [2:0] r_state;
    logic       r_drop;
    logic       w_dm;
    logic       w_stall;
    assign w_dm    = i_dm_rd | i_dm_wr;
    assign w_stall = (w_dm & ~o_dm_done) | (i_if_req & ~o_if_ready);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_drop         <= 1'b0;
            o_mem_req      <= 1'b0;
            o_mem_we       <= 1'b0;
            o_mem_addr     <= '0;
            o_mem_wdata    <= '0;
            o_if_ready     <= 1'b0;
            o_if_instr     <= NOP_INSTR;
            o_dm_done      <= 1'b0;
            o_dm_rdata     <= '0;
            o_stall_cycles <= '0;
        end else begin
            if (w_stall && !(&o_stall_cycles))
                o_stall_cycles <= o_stall_cycles + CNT_W'(1);
            case (r_state)
                IDLE: begin
                    if (w_dm) begin
                        r_state     <= DATA;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= i_dm_wr;
                        o_mem_addr  <= i_dm_addr;
                        o_mem_wdata <= i_dm_wdata;
                    end else if (i_if_req) begin
                        r_state    <= FETCH;
                        o_mem_req  <= 1'b1;
                        o_mem_we   <= 1'b0;
                        o_mem_addr <= i_if_addr;
                        r_drop     <= i_flush;
                    end
                end
                DATA: begin
                    if (i_mem_ack) begin
                        r_state   <= DDONE;
                        o_mem_req <= 1'b0;
                        o_dm_done <= 1'b1;
                        if (!o_mem_we)
                            o_dm_rdata <= i_mem_rdata;
                    end
                end
                DDONE: begin
                    r_state   <= IDLE;
                    o_dm_done <= 1'b0;
                end
                FETCH: begin
                    if (i_mem_ack) begin
                        r_state    <= FDONE;
                        o_mem_req  <= 1'b0;
                        o_if_ready <= 1'b1;
                        o_if_instr <= (r_drop | i_flush) ? NOP_INSTR : i_mem_rdata;
                        r_drop     <= 1'b0;
                    end else if (i_flush) begin
                        r_drop <= 1'b1;
                    end
                end
                FDONE: begin
                    r_state    <= IDLE;
                    o_if_ready <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: directed vector table plus hand-written arbitration and reset sequences
module tb_imem_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_if_req = 1'b0, i_flush = 1'b0, i_dm_rd = 1'b0, i_dm_wr = 1'b0, i_mem_ack = 1'b0;
    logic [31:0] i_if_addr = '0, i_dm_addr = '0, i_dm_wdata = '0, i_mem_rdata = '0;
    logic [31:0] o_if_instr, o_dm_rdata, o_mem_addr, o_mem_wdata;
    logic        o_if_ready, o_dm_done, o_mem_req, o_mem_we;
    logic [15:0] o_stall_cycles;
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_stall = 0;

    imem_dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_flush(i_flush),
        .o_if_instr(o_if_instr), .o_if_ready(o_if_ready),
        .i_dm_rd(i_dm_rd), .i_dm_wr(i_dm_wr), .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
        .o_dm_rdata(o_dm_rdata), .o_dm_done(o_dm_done),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack), .o_stall_cycles(o_stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp;
        int          d;
        logic        fl;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_grant();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!o_mem_req && t < 10);
        chk("grant", {31'd0, o_mem_req}, 32'd1);
    endtask

    task automatic run(input vec_t v);
        int cnt;
        i_dm_rd    = (v.kind == 2'd0);
        i_dm_wr    = (v.kind == 2'd1);
        i_if_req   = (v.kind == 2'd2);
        i_dm_addr  = v.addr;
        i_if_addr  = v.addr;
        i_dm_wdata = v.wdata;
        wait_grant();
        chk("mem_addr", o_mem_addr, v.addr);
        chk("mem_we", {31'd0, o_mem_we}, {31'd0, v.kind == 2'd1});
        if (v.kind == 2'd1)
            chk("mem_wdata", o_mem_wdata, v.wdata);
        cnt = 1;
        for (int i = 0; i < v.d; i++) begin
            i_flush = v.fl && (i == v.d - 1);
            @(negedge clk);
            i_flush = 1'b0;
            cnt += int'(o_mem_req);
            chk("addr_hold", o_mem_addr, v.addr);
        end
        i_mem_ack   = 1'b1;
        i_mem_rdata = v.rdata;
        @(negedge clk);
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'h0BAD_F00D;
        chk("req_cycles", 32'(cnt), 32'(v.d + 1));
        chk("req_drop", {31'd0, o_mem_req}, 32'd0);
        if (v.kind == 2'd2) begin
            chk("if_ready", {31'd0, o_if_ready}, 32'd1);
            chk("if_instr", o_if_instr, v.exp);
            chk("dm_done_idle", {31'd0, o_dm_done}, 32'd0);
        end else begin
            chk("dm_done", {31'd0, o_dm_done}, 32'd1);
            chk("dm_rdata", o_dm_rdata, v.exp);
            chk("if_ready_idle", {31'd0, o_if_ready}, 32'd0);
        end
        @(negedge clk);
        chk("strobe_single", {30'd0, o_if_ready, o_dm_done}, 32'd0);
        chk("no_reissue", {31'd0, o_mem_req}, 32'd0);
        i_dm_rd  = 1'b0;
        i_dm_wr  = 1'b0;
        i_if_req = 1'b0;
        exp_stall += v.d + 2;
        chk("stall", {16'd0, o_stall_cycles}, 32'(exp_stall));
    endtask

    initial begin
        vecs[0] = '{2'd2, 32'h10,  32'h0,        32'hE3A0_1005, 32'hE3A0_1005, 1, 1'b0};
        vecs[1] = '{2'd0, 32'h200, 32'h0,        32'h0000_55AA, 32'h0000_55AA, 0, 1'b0};
        vecs[2] = '{2'd1, 32'h404, 32'hCAFEBABE, 32'hDEAD_BEEF, 32'h0000_55AA, 2, 1'b0};
        vecs[3] = '{2'd2, 32'h20,  32'h0,        32'hEA00_0004, 32'hE000_0000, 1, 1'b1};
        vecs[4] = '{2'd2, 32'h24,  32'h0,        32'hE1A0_0000, 32'hE1A0_0000, 0, 1'b0};
        vecs[5] = '{2'd0, 32'h408, 32'h0,        32'h1234_5678, 32'h1234_5678, 3, 1'b0};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_if_instr", o_if_instr, 32'hE000_0000);
        chk("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
        chk("rst_strobes", {30'd0, o_if_ready, o_dm_done}, 32'd0);
        chk("rst_stall", {16'd0, o_stall_cycles}, 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        chk("rst_dm_rdata", o_dm_rdata, 32'd0);
        foreach (vecs[k]) run(vecs[k]);
        // data and fetch requested together: data first, fetch granted only after DDONE
        i_dm_rd = 1'b1; i_dm_addr = 32'h400; i_if_req = 1'b1; i_if_addr = 32'h30;
        wait_grant();
        chk("pri_addr", o_mem_addr, 32'h400);
        chk("pri_we", {31'd0, o_mem_we}, 32'd0);
        i_mem_ack = 1'b1; i_mem_rdata = 32'h1234;
        @(negedge clk);
        i_mem_ack = 1'b0;
        chk("pri_done", {31'd0, o_dm_done}, 32'd1);
        chk("pri_rdata", o_dm_rdata, 32'h1234);
        chk("pri_no_ready", {31'd0, o_if_ready}, 32'd0);
        @(negedge clk);
        chk("pri_ddone_idle", {31'd0, o_mem_req}, 32'd0);
        i_dm_rd = 1'b0;
        @(negedge clk);
        chk("pri_fetch_req", {31'd0, o_mem_req}, 32'd1);
        chk("pri_fetch_addr", o_mem_addr, 32'h30);
        chk("pri_fetch_noready", {31'd0, o_if_ready}, 32'd0);
        i_mem_ack = 1'b1; i_mem_rdata = 32'hE3A0_2000;
        @(negedge clk);
        i_mem_ack = 1'b0;
        chk("pri_if_ready", {31'd0, o_if_ready}, 32'd1);
        chk("pri_if_instr", o_if_instr, 32'hE3A0_2000);
        i_if_req = 1'b0;
        @(negedge clk);
        chk("pri_ready_single", {31'd0, o_if_ready}, 32'd0);
        exp_stall += 5;
        chk("pri_stall", {16'd0, o_stall_cycles}, 32'(exp_stall));
        // asynchronous reset in the middle of a data access, then a stale ack
        i_dm_rd = 1'b1; i_dm_addr = 32'h500;
        wait_grant();
        rst = 1'b1;
        #1;
        chk("arst_mem_req", {31'd0, o_mem_req}, 32'd0);
        chk("arst_mem_addr", o_mem_addr, 32'd0);
        chk("arst_if_instr", o_if_instr, 32'hE000_0000);
        chk("arst_stall", {16'd0, o_stall_cycles}, 32'd0);
        i_dm_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        i_mem_ack = 1'b1; i_mem_rdata = 32'h7777_7777;
        @(negedge clk);
        i_mem_ack = 1'b0;
        chk("late_ack_req", {31'd0, o_mem_req}, 32'd0);
        chk("late_ack_strobes", {30'd0, o_if_ready, o_dm_done}, 32'd0);
        chk("late_ack_rdata", o_dm_rdata, 32'd0);
        chk("late_ack_stall", {16'd0, o_stall_cycles}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
